// File: rtl/prog_loader.sv
// prog_loader: assembles little-endian program bytes into 32-bit words and writes them to instruction memory while holding the core.
// Optional trailer checksum verification is built in when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] words_q, words_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        hold_q, hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        xfer_s;
  logic [31:0] asm_next_s;

  // A byte moves only when the registered ready and the source's valid coincide.
  assign xfer_s = byte_valid & ready_q;

  // Assembly register with the current byte merged into its little-endian lane.
  always_comb begin
    asm_next_s = asm_q;
    case (bidx_q)
      2'd0:    asm_next_s[7:0]   = byte_data;
      2'd1:    asm_next_s[15:8]  = byte_data;
      2'd2:    asm_next_s[23:16] = byte_data;
      2'd3:    asm_next_s[31:24] = byte_data;
      default: asm_next_s        = asm_q;
    endcase
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_d   = word_count;
          words_d = 11'd0;
          bidx_d  = 2'd0;
          asm_d   = 32'd0;
          addr_d  = BASE_ADDR;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
`endif
          if (word_count == 11'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RECV: begin
        if (xfer_s) begin
          asm_d  = asm_next_s;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = ST_WRITE;
            wdata_d = asm_next_s;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_STEP;
        words_d = words_q + 11'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
`endif
        if ((words_q + 11'd1) < cnt_q) begin
          state_d = ST_RECV;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        // The trailer reuses the assembly register; the sum is final once CHECK is entered.
        if (xfer_s) begin
          asm_d  = asm_next_s;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            error_d = (asm_next_s != sum_q);
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef LOADER_CHECKSUM_EN
    ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
`else
    ready_d = (state_d == ST_RECV);
    error_d = 1'b0;
`endif
    we_d   = (state_d == ST_WRITE);
    busy_d = ready_d | we_d;
    hold_d = !((state_d == ST_DONE) && !error_d);
  end

  // State and output registers; reset forces the idle, core-held condition at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 11'd0;
      words_q <= 11'd0;
      bidx_q  <= 2'd0;
      asm_q   <= 32'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_hold  = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven cycle vectors plus hand sequences for stall, mid-load reset and checksum trailer.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [10:0] wc;
    logic        bv;
    logic [7:0]  bd;
    logic        br;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        hold;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [10:0] wc, input logic bv, input logic [7:0] bd);
    @(negedge clk);
    start      = st;
    word_count = wc;
    byte_valid = bv;
    byte_data  = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) drive(1'b0, 11'd0, 1'b1, w[8*k +: 8]);
  endtask

  // Covers the WRITE cycle of the last word and, when built with the checksum, the trailer.
  task automatic finish_load(input logic [31:0] trailer);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    send_word(trailer);
`else
    if (trailer == 32'd0) n_cmp = n_cmp + 0;
`endif
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      drive(1'b0, 11'd0, 1'b0, 8'h00);
      cyc++;
    end
    check({name, " done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = 11'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    //          st    wc     bv    bd     br    we    addr          wdata         busy  done  hold
    tbl[0]  = '{1'b1, 11'd2, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 11'd0, 1'b1, 8'h13, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 11'd0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 11'd0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 11'd0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0013, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 11'd0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 11'd0, 1'b1, 8'h93, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 11'd0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 11'd0, 1'b1, 8'h10, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 11'd0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0000_0004, 32'h0010_0093, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0008, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 11'd1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 11'd0, 1'b1, 8'hAA, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 11'd5, 1'b1, 8'hBB, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 11'd0, 1'b1, 8'hCC, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 11'd0, 1'b1, 8'hDD, 1'b0, 1'b1, 32'h0000_0000, 32'hDDCC_BBAA, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0000_0004, 32'h0,        1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst mem_we",     {31'd0, mem_we},     32'd0);
    check("rst mem_addr",   mem_addr,            32'h0000_0000);
    check("rst mem_wdata",  mem_wdata,           32'h0000_0000);
    check("rst core_hold",  {31'd0, core_hold},  32'd1);
    check("rst busy",       {31'd0, busy},       32'd0);
    check("rst done",       {31'd0, done},       32'd0);
    check("rst error",      {31'd0, error},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef LOADER_CHECKSUM_EN
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].st, tbl[i].wc, tbl[i].bv, tbl[i].bd);
      check($sformatf("v%0d byte_ready", i), {31'd0, byte_ready}, {31'd0, tbl[i].br});
      check($sformatf("v%0d mem_we", i),     {31'd0, mem_we},     {31'd0, tbl[i].we});
      check($sformatf("v%0d mem_addr", i),   mem_addr,            tbl[i].addr);
      check($sformatf("v%0d busy", i),       {31'd0, busy},       {31'd0, tbl[i].busy});
      check($sformatf("v%0d done", i),       {31'd0, done},       {31'd0, tbl[i].done});
      check($sformatf("v%0d core_hold", i),  {31'd0, core_hold},  {31'd0, tbl[i].hold});
      check($sformatf("v%0d error", i),      {31'd0, error},      32'd0);
      if (tbl[i].we) check($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].wdata);
    end
`endif

    // Stall five cycles after the second byte of a word.
    drive(1'b1, 11'd1, 1'b0, 8'h00);
    drive(1'b0, 11'd0, 1'b1, 8'h11);
    drive(1'b0, 11'd0, 1'b1, 8'h22);
    n = log_addr.size();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 11'd0, 1'b0, 8'hEE);
      check($sformatf("stall%0d byte_ready", k), {31'd0, byte_ready}, 32'd1);
      check($sformatf("stall%0d mem_we", k),     {31'd0, mem_we},     32'd0);
    end
    drive(1'b0, 11'd0, 1'b1, 8'h33);
    drive(1'b0, 11'd0, 1'b1, 8'h44);
    finish_load(32'h4433_2211);
    wait_done("stall");
    check("stall write count", log_addr.size(), n + 1);
    if (log_addr.size() > n) begin
      check("stall addr", log_addr[n], 32'h0000_0000);
      check("stall data", log_data[n], 32'h4433_2211);
    end

    // Reset after six of eight bytes, then confirm no write and a clean restart.
    drive(1'b1, 11'd2, 1'b0, 8'h00);
    send_word(32'h0403_0201);
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    drive(1'b0, 11'd0, 1'b1, 8'h05);
    drive(1'b0, 11'd0, 1'b1, 8'h06);
    check("pre-rst mem_addr", mem_addr, 32'h0000_0004);
    n = log_addr.size();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst byte_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst mem_we",     {31'd0, mem_we},     32'd0);
    check("midrst mem_addr",   mem_addr,            32'h0000_0000);
    check("midrst busy",       {31'd0, busy},       32'd0);
    check("midrst core_hold",  {31'd0, core_hold},  32'd1);
    check("midrst done",       {31'd0, done},       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(1'b0, 11'd0, 1'b1, 8'hFF);
    check("postrst writes", log_addr.size(), n);
    check("postrst busy", {31'd0, busy}, 32'd0);
    check("postrst byte_ready", {31'd0, byte_ready}, 32'd0);
    drive(1'b1, 11'd2, 1'b0, 8'h00);
    send_word(32'hDEAD_BEEF);
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    send_word(32'h1234_5678);
    finish_load(32'hDEAD_BEEF + 32'h1234_5678);
    wait_done("restart");
    check("restart write count", log_addr.size(), n + 2);
    if (log_addr.size() > n + 1) begin
      check("restart addr0", log_addr[n],     32'h0000_0000);
      check("restart data0", log_data[n],     32'hDEAD_BEEF);
      check("restart addr1", log_addr[n + 1], 32'h0000_0004);
      check("restart data1", log_data[n + 1], 32'h1234_5678);
    end
    check("restart core_hold", {31'd0, core_hold}, 32'd0);
    check("restart error", {31'd0, error}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 11'd2, 1'b0, 8'h00);
    send_word(32'h0000_0001);
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    send_word(32'h0000_0002);
    finish_load(32'h0000_0003);
    wait_done("cks good");
    check("cks good error", {31'd0, error}, 32'd0);
    check("cks good core_hold", {31'd0, core_hold}, 32'd0);
    drive(1'b1, 11'd2, 1'b0, 8'h00);
    send_word(32'h0000_0001);
    drive(1'b0, 11'd0, 1'b0, 8'h00);
    send_word(32'h0000_0002);
    finish_load(32'h0000_0004);
    wait_done("cks bad");
    check("cks bad error", {31'd0, error}, 32'd1);
    check("cks bad core_hold", {31'd0, core_hold}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, address written for the first instruction word.
REQ-002 Parameter: ADDR_STEP, 4, increment of mem_addr between consecutive words.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-006 Port: word_count  input  11  number of words to load (0..1024); latched when start is accepted.
REQ-007 Port: byte_valid  input  1  a byte is offered on byte_data.
REQ-008 Port: byte_data  input  8  incoming program byte, little-endian within each word.
REQ-009 Port: byte_ready  output  1  loader accepts a byte; a transfer occurs when byte_valid and byte_ready are both high.
REQ-010 Port: mem_we  output  1  instruction-memory write strobe.
REQ-011 Port: mem_addr  output  32  instruction-memory write address.
REQ-012 Port: mem_wdata  output  32  instruction-memory write data.
REQ-013 Port: core_hold  output  1  holds the core's PC and register writes while high.
REQ-014 Port: busy  output  1  a load is in progress.
REQ-015 Port: done  output  1  the last load completed; sticky until the next accepted start.
REQ-016 Port: error  output  1  checksum mismatch on the last load.

Function
REQ-017 The FSM states SHALL be IDLE, RECV, WRITE, CHECK and DONE.
REQ-018 IDLE or DONE with start=1: latch word_count, clear the byte index and word counter, set mem_addr=BASE_ADDR, clear done and error, go to RECV; if word_count=0, go directly to DONE.
REQ-019 RECV: byte_ready=1; each transfer places byte_data in bits [8*i+7:8*i] of the assembly register (i=0..3), then i increments.
REQ-020 The 4th transfer of a word SHALL move the FSM to WRITE on the next edge.
REQ-021 WRITE: lasts exactly 1 cycle with mem_we=1, mem_wdata=assembled word, mem_addr=current address, byte_ready=0.
REQ-022 Leaving WRITE: mem_addr increments by ADDR_STEP (mod 2^32) and the word counter increments; go to RECV if words remain, otherwise CHECK (macro defined) or DONE.
REQ-023 byte_valid low in RECV SHALL stall without losing partial-word state; there is no timeout.
REQ-024 start outside IDLE/DONE SHALL be ignored.
REQ-025 busy=1 in RECV, WRITE and CHECK; core_hold=1 in every state except DONE with error=0.
REQ-026 mem_we SHALL be 0 in every state other than WRITE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_hold=1, busy=0, done=0, error=0, and clear all counters and the checksum.
REQ-028 Reset asserted mid-load SHALL abandon the load; no further mem_we pulse SHALL occur until a new start.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: a 32-bit running sum (mod 2^32) of every written word is kept; after the last WRITE, CHECK receives 4 more bytes (little-endian trailer, byte_ready=1) then enters DONE with error=1 if trailer differs from sum, else error=0.
REQ-030 Macro LOADER_CHECKSUM_EN undefined: no CHECK state, no trailer bytes are consumed, error is held at 0.

Verification
REQ-031 Reset, start with word_count=2, bytes 13 00 00 00 93 00 10 00 -> mem_we pulses at addr 0 data 32'h0000_0013 and addr 4 data 32'h0010_0093; done=1, core_hold=0.
REQ-032 word_count=0 with start -> DONE the next cycle, no mem_we pulse, done=1.
REQ-033 byte_valid deasserted for 5 cycles after the 2nd byte of a word -> same word written, one mem_we pulse, no byte lost.
REQ-034 rst_n pulsed low after 6 of 8 bytes -> immediate IDLE, mem_addr=0, no further write; restart loads correctly from addr 0.
REQ-035 With LOADER_CHECKSUM_EN, words 32'h1 and 32'h2 followed by trailer 03 00 00 00 -> error=0, core_hold=0; trailer 04 00 00 00 -> error=1, done=1, core_hold=1.
REQ-036 start pulsed during RECV -> ignored; counters and mem_addr sequence unchanged.
